// File: rtl/apb_fifo_pkg.sv
// Shared register offsets, STATUS/CTRL bit positions and APB FSM state type
// for the APB FIFO completer.
package apb_fifo_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;
   localparam logic [1:0] ADDR_THRESH = 2'd3;

   localparam int STAT_EMPTY   = 0;
   localparam int STAT_FULL    = 1;
   localparam int STAT_OVF     = 2;
   localparam int STAT_UNF     = 3;
   localparam int STAT_CNT_LSB = 8;

   localparam int CTRL_FLUSH = 0;
   localparam int CTRL_CLR   = 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } apb_state_e;

endpackage

// File: rtl/apb_fifo_slave_sync_fifo.sv
// Synchronous FIFO with push/pop/flush; pushes when full and pops when empty
// are ignored here and reported by the caller.
module sync_fifo #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 32
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_push,
   input  logic                      i_pop,
   input  logic                      i_flush,
   input  logic [DATA_W-1:0]         i_wdata,
   output logic [DATA_W-1:0]         o_rdata,
   output logic                      o_full,
   output logic                      o_empty,
   output logic [$clog2(DEPTH):0]    o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic              w_do_push;
   logic              w_do_pop;

   assign o_full    = (r_count == FULL_CNT);
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/apb_fifo_slave.sv
// APB completer exposing a sync FIFO with programmable wait states.
// Optional level interrupt output enabled by defining APB_FIFO_IRQ_EN.
module apb_fifo_slave
   import apb_fifo_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic [31:0]       PADDR,
   input  logic              PWRITE,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic [DATA_W-1:0] PWDATA,
   output logic [DATA_W-1:0] PRDATA,
   output logic              PREADY
`ifdef APB_FIFO_IRQ_EN
   ,
   output logic              irq
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

   apb_state_e        r_state;
   logic [3:0]        r_cnt;
   logic              r_pready;
   logic [DATA_W-1:0] r_prdata;
   logic              r_ovf;
   logic              r_unf;
   logic [7:0]        r_thresh;

   logic [1:0]        w_addr;
   logic              w_commit;
   logic              w_push;
   logic              w_pop;
   logic              w_flush;
   logic              w_clr;
   logic [DATA_W-1:0] w_head;
   logic              w_full;
   logic              w_empty;
   logic [CW-1:0]     w_count;
   logic [DATA_W-1:0] w_rd_value;
   logic              w_unused;

   assign w_addr   = PADDR[3:2];
   assign w_unused = ^{PADDR[31:4], PADDR[1:0]};
   assign w_commit = (r_state == ACCESS) && PSEL && PENABLE && (r_cnt == WAIT_L);
   assign w_push   = w_commit && PWRITE && (w_addr == ADDR_DATA);
   assign w_pop    = w_commit && !PWRITE && (w_addr == ADDR_DATA);
   assign w_flush  = w_commit && PWRITE && (w_addr == ADDR_CTRL) && PWDATA[CTRL_FLUSH];
   assign w_clr    = w_commit && PWRITE && (w_addr == ADDR_CTRL) && PWDATA[CTRL_CLR];
   assign PREADY   = r_pready;
   assign PRDATA   = r_prdata;

   sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
      .i_clk   (PCLK),
      .i_rst   (PRESET),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_wdata (PWDATA),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_comb begin
      w_rd_value = '0;
      case (w_addr)
         ADDR_DATA: begin
            if (!w_empty) w_rd_value = w_head;
            else          w_rd_value = '0;
         end
         ADDR_STATUS: begin
            w_rd_value[STAT_EMPTY]           = w_empty;
            w_rd_value[STAT_FULL]            = w_full;
            w_rd_value[STAT_OVF]             = r_ovf;
            w_rd_value[STAT_UNF]             = r_unf;
            w_rd_value[STAT_CNT_LSB +: 8]    = 8'(w_count);
         end
         ADDR_THRESH: w_rd_value[7:0] = r_thresh;
         default:     w_rd_value = '0;
      endcase
   end

   // Transfer FSM: everything commits on the ACCESS->RESP edge.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state  <= IDLE;
         r_cnt    <= 4'd0;
         r_pready <= 1'b0;
         r_prdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_pready <= 1'b0;
               r_prdata <= '0;
               if (PSEL && !PENABLE) begin
                  r_state <= ACCESS;
                  r_cnt   <= 4'd0;
               end else begin
                  r_state <= IDLE;
               end
            end
            ACCESS: begin
               if (!PSEL) begin
                  r_state <= IDLE;
               end else if (PENABLE) begin
                  if (r_cnt == WAIT_L) begin
                     r_state  <= RESP;
                     r_pready <= 1'b1;
                     r_prdata <= PWRITE ? '0 : w_rd_value;
                  end else begin
                     r_cnt <= r_cnt + 4'd1;
                  end
               end else begin
                  r_state <= ACCESS;
               end
            end
            RESP: begin
               r_state  <= IDLE;
               r_pready <= 1'b0;
               r_prdata <= '0;
            end
            default: begin
               r_state  <= IDLE;
               r_pready <= 1'b0;
               r_prdata <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
         r_thresh <= 8'd0;
      end else begin
         if (w_clr) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
         end else begin
            if (w_push && w_full)  r_ovf <= 1'b1;
            if (w_pop && w_empty)  r_unf <= 1'b1;
         end
         if (w_commit && PWRITE && (w_addr == ADDR_THRESH)) r_thresh <= PWDATA[7:0];
      end
   end

`ifdef APB_FIFO_IRQ_EN
   logic r_irq;
   assign irq = r_irq;

   // Sampled from committed state, so it trails the causing commit by one cycle.
   always_ff @(posedge PCLK) begin
      if (PRESET) r_irq <= 1'b0;
      else        r_irq <= (9'(w_count) > {1'b0, r_thresh}) | r_ovf;
   end
`endif

endmodule

// File: tb/tb_apb_fifo_slave.sv
// Randomised scoreboard bench for apb_fifo_slave against a queue-based model.
module tb_apb_fifo_slave;

   localparam int DEPTH = 16;
   localparam int WAITC = 3;

   logic        PCLK = 1'b0;
   logic        PRESET;
   logic [31:0] PADDR;
   logic        PWRITE;
   logic        PSEL;
   logic        PENABLE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
`ifdef APB_FIFO_IRQ_EN
   logic        irq;
`endif

   always #5 PCLK = ~PCLK;

   apb_fifo_slave #(.DEPTH(DEPTH), .DATA_W(32), .WAIT_CYCLES(WAITC)) dut (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .PADDR   (PADDR),
      .PWRITE  (PWRITE),
      .PSEL    (PSEL),
      .PENABLE (PENABLE),
      .PWDATA  (PWDATA),
      .PRDATA  (PRDATA),
      .PREADY  (PREADY)
`ifdef APB_FIFO_IRQ_EN
      ,
      .irq     (irq)
`endif
   );

   typedef struct packed {
      logic        chk;
      logic [31:0] data;
   } exp_t;

   exp_t        sbq[$];
   exp_t        mon_e;
   logic [31:0] mq[$];
   bit          m_ovf = 1'b0;
   bit          m_unf = 1'b0;
   int          m_thr = 0;
   bit          m_irq = 1'b0;
   int          n_checks = 0;
   int          n_fail = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [31:0] model_status();
      logic [31:0] s;
      s       = 32'd0;
      s[0]    = (mq.size() == 0);
      s[1]    = (mq.size() == DEPTH);
      s[2]    = m_ovf;
      s[3]    = m_unf;
      s[15:8] = 8'(mq.size());
      return s;
   endfunction

   function automatic void model_reset();
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_thr = 0;
      m_irq = 1'b0;
   endfunction

   // Scoreboard monitor: every PREADY pulse consumes one expected response.
   always @(negedge PCLK) begin
      if (!PRESET && PREADY) begin
         if (sbq.size() == 0) begin
            check("unexpected_pready", 32'd1, 32'd0);
         end else begin
            mon_e = sbq.pop_front();
            if (mon_e.chk) check("prdata", PRDATA, mon_e.data);
         end
      end
   end

   task automatic drive_setup(input bit wr, input logic [1:0] sel, input logic [31:0] wdata);
      logic [31:0] junk;
      junk    = $urandom();
      @(negedge PCLK);
      PSEL    = 1'b1;
      PENABLE = 1'b0;
      PWRITE  = wr;
      PADDR   = {junk[31:4], sel, junk[1:0]};
      PWDATA  = wdata;
      @(negedge PCLK);
      PENABLE = 1'b1;
   endtask

   task automatic apb(input bit wr, input logic [1:0] sel, input logic [31:0] wdata);
      exp_t e;
      bit   got;
      int   lat;
      e.chk  = !wr;
      e.data = 32'd0;
      if (wr) begin
         case (sel)
            2'd0: if (mq.size() == DEPTH) m_ovf = 1'b1; else mq.push_back(wdata);
            2'd2: begin
               if (wdata[0]) mq.delete();
               if (wdata[1]) begin m_ovf = 1'b0; m_unf = 1'b0; end
            end
            2'd3: m_thr = int'(wdata[7:0]);
            default: ;
         endcase
      end else begin
         case (sel)
            2'd0: if (mq.size() == 0) m_unf = 1'b1; else e.data = mq.pop_front();
            2'd1: e.data = model_status();
            2'd3: e.data = 32'(m_thr);
            default: e.data = 32'd0;
         endcase
      end
      sbq.push_back(e);
      drive_setup(wr, sel, wdata);
      got = 1'b0;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge PCLK);
         if (PREADY) begin
            got = 1'b1;
            lat = k + 1;
            break;
         end
      end
      if (!got) begin
         check("pready_timeout", 32'd0, 32'd1);
         void'(sbq.pop_back());
      end else begin
         check("latency", 32'(lat), 32'(WAITC + 2));
`ifdef APB_FIFO_IRQ_EN
         check("irq_before_update", 32'(irq), 32'(m_irq));
`endif
      end
      m_irq   = (mq.size() > m_thr) || m_ovf;
      PSEL    = 1'b0;
      PENABLE = 1'b0;
      @(negedge PCLK);
      check("pready_one_cycle", 32'(PREADY), 32'd0);
`ifdef APB_FIFO_IRQ_EN
      check("irq_after_commit", 32'(irq), 32'(m_irq));
`endif
   endtask

   initial begin
      bit seen;
      int r;
      PRESET  = 1'b1;
      PSEL    = 1'b0;
      PENABLE = 1'b0;
      PWRITE  = 1'b0;
      PADDR   = 32'd0;
      PWDATA  = 32'd0;
      repeat (3) @(negedge PCLK);
      check("reset_pready", 32'(PREADY), 32'd0);
      check("reset_prdata", PRDATA, 32'd0);
`ifdef APB_FIFO_IRQ_EN
      check("reset_irq", 32'(irq), 32'd0);
`endif
      PRESET = 1'b0;

      for (int i = 10; i <= 12; i++) apb(1'b1, 2'd0, 32'(i));
      repeat (3) apb(1'b0, 2'd0, 32'd0);
      apb(1'b0, 2'd1, 32'd0);

      for (int i = 0; i <= DEPTH; i++) apb(1'b1, 2'd0, 32'h100 + 32'(i));
      apb(1'b0, 2'd1, 32'd0);
      repeat (DEPTH + 1) apb(1'b0, 2'd0, 32'd0);
      apb(1'b0, 2'd1, 32'd0);
      apb(1'b1, 2'd2, 32'd2);
      apb(1'b0, 2'd1, 32'd0);

      repeat (5) apb(1'b1, 2'd0, $urandom());
      apb(1'b1, 2'd2, 32'd1);
      apb(1'b0, 2'd1, 32'd0);
      apb(1'b0, 2'd2, 32'd0);

      apb(1'b1, 2'd3, 32'd2);
      apb(1'b0, 2'd3, 32'd0);
      repeat (3) apb(1'b1, 2'd0, $urandom());
      apb(1'b0, 2'd0, 32'd0);
      apb(1'b0, 2'd1, 32'd0);

      for (int i = 0; i <= DEPTH; i++) apb(1'b1, 2'd0, $urandom());
      apb(1'b0, 2'd0, 32'd0);
      apb(1'b1, 2'd2, 32'd3);
      apb(1'b0, 2'd1, 32'd0);

      // Abort in access phase: no side effect and no PREADY.
      apb(1'b1, 2'd0, 32'h55);
      drive_setup(1'b1, 2'd0, 32'hDEAD_BEEF);
      @(negedge PCLK);
      PSEL    = 1'b0;
      PENABLE = 1'b0;
      seen    = 1'b0;
      repeat (6) begin
         @(negedge PCLK);
         seen |= PREADY;
      end
      check("abort_no_pready", 32'(seen), 32'd0);
      apb(1'b0, 2'd1, 32'd0);

      // Reset in the middle of an access phase.
      apb(1'b1, 2'd0, 32'h77);
      drive_setup(1'b1, 2'd0, 32'hCAFE_0001);
      @(negedge PCLK);
      PRESET = 1'b1;
      @(negedge PCLK);
      check("reset_mid_pready", 32'(PREADY), 32'd0);
      PSEL    = 1'b0;
      PENABLE = 1'b0;
      model_reset();
      @(negedge PCLK);
`ifdef APB_FIFO_IRQ_EN
      check("reset_mid_irq", 32'(irq), 32'd0);
`endif
      PRESET = 1'b0;
      apb(1'b0, 2'd1, 32'd0);
      apb(1'b0, 2'd3, 32'd0);

      for (int i = 0; i < 120; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2, 3: apb(1'b1, 2'd0, $urandom());
            4, 5, 6:    apb(1'b0, 2'd0, 32'd0);
            7:          apb(1'b0, 2'd1, 32'd0);
            8: begin
               if ($urandom_range(0, 1) == 1) apb(1'b1, 2'd3, 32'($urandom_range(0, 20)));
               else                           apb(1'b0, 2'd3, 32'd0);
            end
            default: begin
               if ($urandom_range(0, 2) == 0) apb(1'b1, 2'd2, $urandom());
               else                           apb(1'b0, 2'd2, 32'd0);
            end
         endcase
      end
      apb(1'b0, 2'd1, 32'd0);

      repeat (2) @(negedge PCLK);
      check("sb_drained", 32'(sbq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
